event_word_serializer: RTL and testbench

- Sits directly downstream of sync_fifo and drains it.
- Pops one FIFO_DWIDTH event word at a time and emits it as IN_DWIDTH/OUT_DWIDTH narrower beats on a valid/ready stream toward the output interface.
- Beats are emitted most-significant slice first.
- Supports back-to-back words at full beat rate and a synchronous abort.

---
 rtl/evt_stream_pkg.sv | 11 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/event_word_serializer.sv | 96 +++++++++
 tb/tb_event_word_serializer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_stream_pkg.sv
// Shared widths and types for the event-word streaming path.
package evt_stream_pkg;

    localparam int EVT_WORD_W = 64;
    localparam int EVT_BEAT_W = 16;

    typedef enum logic {IDLE, SEND} ser_state_e;

    typedef logic [EVT_WORD_W-1:0] evt_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on rdata_o whenever empty_o=0.
module sync_fifo #(
    parameter int FIFO_DWIDTH = 64,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [FIFO_DWIDTH-1:0] wdata_i,
    input  logic                   rd_en_i,
    output logic [FIFO_DWIDTH-1:0] rdata_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FIFO_DWIDTH-1:0] mem_q [FIFO_DEPTH];
    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic                   do_wr, do_rd;

    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/event_word_serializer.sv
// Drains a FWFT FIFO one event word at a time and streams it out as narrower beats,
// most-significant slice first, with back-to-back words at full beat rate.
//
// state | meaning
// IDLE  | no word held; pops the FIFO head as soon as it is non-empty
// SEND  | word held in the shift register; top slice presented on out_data
module event_word_serializer
    import evt_stream_pkg::*;
#(
    parameter int IN_DWIDTH  = EVT_WORD_W,
    parameter int OUT_DWIDTH = EVT_BEAT_W,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [IN_DWIDTH-1:0]  fifo_rdata,
    output logic                  fifo_rd_en,
    input  logic                  clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_DWIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int BEATS = IN_DWIDTH / OUT_DWIDTH;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((IN_DWIDTH % OUT_DWIDTH) != 0 || BEATS < 1) begin : g_bad_width
        $error("IN_DWIDTH must be a non-zero integer multiple of OUT_DWIDTH");
    end

    ser_state_e           state_q, state_d;
    logic [IN_DWIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]       beat_q, beat_d;
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                 send, beat_acc, last_beat, pop;

    assign send      = (state_q == SEND);
    assign beat_acc  = send && out_ready;
    assign last_beat = (beat_q == BCW'(BEATS - 1));
    // Gated by rst_n so the FIFO head is never consumed while this block is held in reset.
    assign pop       = rst_n && !clr && !fifo_empty && (!send || (beat_acc && last_beat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        if (clr) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            if (beat_acc && last_beat) wcnt_d = wcnt_q + 1'b1;
            if (pop) begin
                state_d = SEND;
                shreg_d = fifo_rdata;
                beat_d  = '0;
            end else if (beat_acc) begin
                if (last_beat) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    shreg_d = shreg_q << OUT_DWIDTH;
                    beat_d  = beat_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        fifo_rd_en = pop;
        out_valid  = send;
        busy       = send;
        out_last   = send && last_beat;
        out_data   = send ? shreg_q[IN_DWIDTH-1 -: OUT_DWIDTH] : '0;
        word_cnt   = wcnt_q;
    end

endmodule

// File: tb/tb_event_word_serializer.sv
// Bench: sync_fifo feeding the serializer, checked every cycle against a word-queue model.
module tb_event_word_serializer;
    import evt_stream_pkg::*;

    localparam int IW    = 64;
    localparam int OW    = 16;
    localparam int BEATS = IW / OW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_rst_n = 1'b0;
    logic        wr_en = 1'b0;
    evt_word_t   wdata = '0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;

    logic        fifo_empty, fifo_full, fifo_rd_en;
    evt_word_t   fifo_rdata;
    logic        out_valid, out_last, busy;
    logic [15:0] out_data, word_cnt;
    logic        rd_en2, ov2, ol2, b2;
    logic [15:0] od2;
    logic [3:0]  wc4;

    always #5 clk = ~clk;

    sync_fifo #(.FIFO_DWIDTH(64), .FIFO_DEPTH(16)) u_fifo (
        .clk(clk), .rst_n(fifo_rst_n), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(fifo_rd_en), .rdata_o(fifo_rdata), .empty_o(fifo_empty), .full_o(fifo_full)
    );

    event_word_serializer #(.IN_DWIDTH(IW), .OUT_DWIDTH(OW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .word_cnt(word_cnt)
    );

    // Narrow-counter copy sees the same inputs; only its pop strobe is left off the FIFO.
    event_word_serializer #(.IN_DWIDTH(IW), .OUT_DWIDTH(OW), .CNT_WIDTH(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(rd_en2), .clr(clr), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .out_last(ol2), .busy(b2), .word_cnt(wc4)
    );

    int n_cmp = 0;
    int n_err = 0;

    evt_word_t   mq[$];
    bit          m_held = 0;
    evt_word_t   m_word = '0;
    int          m_idx = 0;
    int          m_wcnt = 0;
    int          cyc = 0;
    int          dut_pops = 0;
    logic [15:0] acc[$];
    int          acc_cyc[$];
    bit          acc_last[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] beat_of(input evt_word_t w, input int k);
        evt_word_t s;
        s = w >> (OW * (BEATS - 1 - k));
        return s[15:0];
    endfunction

    always @(negedge clk) begin
        logic [15:0] e_data;
        bit          e_last, e_rd, e_acc;
        cyc++;
        if (!rst_n) begin
            m_held = 0;
            m_idx  = 0;
            m_wcnt = 0;
            chk("rst_valid", out_valid, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_data", out_data, 0);
            chk("rst_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_wcnt", word_cnt, 0);
            chk("rst_wc4", wc4, 0);
        end else begin
            e_last = m_held && (m_idx == BEATS - 1);
            e_data = m_held ? beat_of(m_word, m_idx) : 16'h0;
            e_rd   = !clr && (mq.size() != 0) && (!m_held || (out_ready && e_last));
            chk("out_valid", out_valid, m_held);
            chk("busy", busy, m_held);
            chk("out_data", out_data, e_data);
            chk("out_last", out_last, e_last);
            chk("fifo_rd_en", fifo_rd_en, e_rd);
            chk("word_cnt", word_cnt, 64'(m_wcnt % 65536));
            chk("w4_word_cnt", wc4, 64'(m_wcnt % 16));
            chk("w4_valid", ov2, m_held);
            chk("w4_data", od2, e_data);
            chk("w4_last", ol2, e_last);
            chk("w4_busy", b2, m_held);
            chk("w4_rd_en", rd_en2, e_rd);
            chk("fifo_empty", fifo_empty, mq.size() == 0);
            if (mq.size() != 0) chk("fifo_head", fifo_rdata, mq[0]);
            if (fifo_rd_en) dut_pops++;
            e_acc = m_held && out_ready && !clr;
            if (clr) begin
                m_held = 0;
                m_idx  = 0;
            end else begin
                if (e_acc) begin
                    acc.push_back(e_data);
                    acc_cyc.push_back(cyc);
                    acc_last.push_back(e_last);
                    if (e_last) begin
                        m_wcnt++;
                        m_held = 0;
                    end else begin
                        m_idx++;
                    end
                end
                if (e_rd) begin
                    m_word = mq.pop_front();
                    m_held = 1;
                    m_idx  = 0;
                end
            end
        end
        if (!fifo_rst_n) mq.delete();
        else if (wr_en && mq.size() < 16) mq.push_back(wdata);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        acc.delete();
        acc_cyc.delete();
        acc_last.delete();
        dut_pops = 0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        fifo_rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        fifo_rst_n = 1'b1;
        tick();
        clear_log();
    endtask

    task automatic push_word(input evt_word_t w);
        int n;
        n = 0;
        while (fifo_full && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("push_timeout", 1, 0);
        wr_en = 1'b1;
        wdata = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k;
        k = 0;
        while (acc.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (acc.size() < n) chk("beat_wait_timeout", 64'(acc.size()), 64'(n));
    endtask

    initial begin
        evt_word_t wl[$];
        bit        pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int        k;

        // Single word, always ready
        do_reset();
        out_ready = 1'b1;
        push_word(64'h0123_4567_89AB_CDEF);
        wait_acc(4, 20);
        tick();
        tick();
        if (acc.size() >= 4) begin
            chk("t1_b0", acc[0], 16'h0123);
            chk("t1_b1", acc[1], 16'h4567);
            chk("t1_b2", acc[2], 16'h89AB);
            chk("t1_b3", acc[3], 16'hCDEF);
            chk("t1_last", {acc_last[0], acc_last[1], acc_last[2], acc_last[3]}, 4'b0001);
            chk("t1_consec", 64'(acc_cyc[3] - acc_cyc[0]), 3);
        end
        chk("t1_pops", 64'(dut_pops), 1);
        chk("t1_wcnt", word_cnt, 1);
        chk("t1_empty", fifo_empty, 1);
        chk("t1_busy", busy, 0);

        // Back-to-back: 16 random words
        do_reset();
        wl.delete();
        for (int i = 0; i < 16; i++) begin
            wl.push_back({$urandom, $urandom});
            push_word(wl[i]);
        end
        out_ready = 1'b1;
        wait_acc(64, 200);
        tick();
        tick();
        if (acc.size() >= 64) begin
            for (int i = 0; i < 64; i++) chk("t2_beat", acc[i], beat_of(wl[i / 4], i % 4));
            chk("t2_consec", 64'(acc_cyc[63] - acc_cyc[0]), 63);
        end
        chk("t2_pops", 64'(dut_pops), 16);
        chk("t2_wcnt", word_cnt, 16);

        // Backpressure 1,0,0,1,0,1,1
        do_reset();
        push_word(64'hDEAD_BEEF_CAFE_F00D);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("t3_valid_seen", out_valid, 1);
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            tick();
        end
        out_ready = 1'b0;
        tick();
        chk("t3_count", 64'(acc.size()), 4);
        if (acc.size() >= 4) begin
            chk("t3_b0", acc[0], 16'hDEAD);
            chk("t3_b1", acc[1], 16'hBEEF);
            chk("t3_b2", acc[2], 16'hCAFE);
            chk("t3_b3", acc[3], 16'hF00D);
        end
        chk("t3_pops", 64'(dut_pops), 1);
        chk("t3_wcnt", word_cnt, 1);

        // Abort after two beats
        do_reset();
        out_ready = 1'b1;
        push_word(64'hFFFF_0000_AAAA_5555);
        push_word(64'h1111_2222_3333_4444);
        wait_acc(2, 20);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_valid_after_clr", out_valid, 0);
        chk("t4_wcnt_after_clr", word_cnt, 0);
        wait_acc(6, 20);
        tick();
        if (acc.size() >= 6) begin
            chk("t4_b0", acc[0], 16'hFFFF);
            chk("t4_b1", acc[1], 16'h0000);
            chk("t4_next0", acc[2], 16'h1111);
            chk("t4_next3", acc[5], 16'h4444);
        end
        chk("t4_wcnt", word_cnt, 1);
        chk("t4_pops", 64'(dut_pops), 2);

        // Reset during beat 3
        do_reset();
        out_ready = 1'b1;
        push_word(64'h1357_9BDF_2468_ACE0);
        push_word(64'hFEDC_BA98_7654_3210);
        wait_acc(2, 20);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_rd_en", fifo_rd_en, 0);
        chk("t5_data", out_data, 0);
        chk("t5_last", out_last, 0);
        chk("t5_busy", busy, 0);
        chk("t5_wcnt", word_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_acc(6, 30);
        tick();
        if (acc.size() >= 6) begin
            chk("t5_b0", acc[2], 16'hFEDC);
            chk("t5_b3", acc[5], 16'h3210);
        end
        chk("t5_wcnt_after", word_cnt, 1);
        chk("t5_empty", fifo_empty, 1);

        // Counter wrap on the 4-bit instance
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word({$urandom, $urandom});
        wait_acc(68, 400);
        tick();
        tick();
        chk("t6_wc4", wc4, 4'd1);
        chk("t6_wcnt", word_cnt, 17);

        // Randomized traffic with occasional aborts
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wr_en = ($urandom_range(2) != 0) && !fifo_full;
            wdata = {$urandom, $urandom};
            out_ready = ($urandom_range(3) != 0);
            clr = ($urandom_range(63) == 0);
            tick();
        end
        wr_en = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        chk("rand_drained", fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
